// File: rtl/uart_pkg.sv
// Shared UART definitions for the parity transmitter and receiver.
//   - uart_state_e    : frame state encoding (3-bit)
//   - TICKS_PER_BIT   : oversampling ticks per serial bit
//   - DBIT_DEFAULT    : default data width
//   - SB_TICK_DEFAULT : default stop-state tick count
//   - EVEN / ODD      : parity-mode selectors
package uart_pkg;

    localparam int unsigned TICKS_PER_BIT   = 16;
    localparam int unsigned DBIT_DEFAULT    = 8;
    localparam int unsigned SB_TICK_DEFAULT = 16;

    localparam bit EVEN = 1'b0;
    localparam bit ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_parity_if.sv
// Request/serial-line bundle of the parity UART transmitter.
//   master : requester side (drives tx_start, s_tick, din)
//   slave  : transmitter side (drives tx, busy, tx_done_tick)
interface uart_tx_parity_if;

    logic       tx_start;
    logic       s_tick;
    logic [7:0] din;
    logic       tx;
    logic       busy;
    logic       tx_done_tick;

    modport master (
        output tx_start, s_tick, din,
        input  tx, busy, tx_done_tick
    );

    modport slave (
        input  tx_start, s_tick, din,
        output tx, busy, tx_done_tick
    );

endinterface

// File: rtl/uart_tx_parity.sv
// UART transmitter with parity: start bit, DBIT data bits LSB first,
// one parity bit, then SB_TICK ticks of stop, paced by a 16x s_tick.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave modport (tx_start, s_tick, din in; tx, busy,
//             tx_done_tick out). tx is registered, busy is decoded from
//             the state register, tx_done_tick is a one-cycle
//             combinational pulse on the final stop tick.
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int unsigned DBIT       = DBIT_DEFAULT,
    parameter int unsigned SB_TICK    = SB_TICK_DEFAULT,
    parameter bit          PARITY_ODD = EVEN
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_tx_parity_if.slave  bus
);

    localparam int unsigned SW = (SB_TICK > 16) ? 5 : 4;
    localparam int unsigned NW = 3;

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_q, p_d;
    logic            tx_q, tx_d;
    logic            done_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
        end
    end

    // Next state, datapath update and line level; tx_d follows the
    // current state so the line lags each state change by one clock.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        tx_d    = tx_q;
        done_c  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_start) begin
                    b_d     = bus.din[DBIT-1:0];
                    p_d     = PARITY_ODD;
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bus.s_tick) begin
                    if (s_q == SW'(TICKS_PER_BIT - 1)) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                tx_d = b_q[0];
                if (bus.s_tick) begin
                    if (s_q == SW'(TICKS_PER_BIT - 1)) begin
                        s_d = '0;
                        // Parity accumulates each bit as it leaves the shifter
                        p_d = p_q ^ b_q[0];
                        b_d = b_q >> 1;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = PARITY;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                tx_d = p_q;
                if (bus.s_tick) begin
                    if (s_q == SW'(TICKS_PER_BIT - 1)) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bus.s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx           = tx_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.tx_done_tick = done_c;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: an even-parity and an odd-parity instance
// share one stimulus stream; a per-instance line decoder samples each
// bit mid-period and checks it against a word/parity model.
module tb_uart_tx_parity;

    localparam int DBIT      = 8;
    localparam int SB_TICK   = 16;
    localparam int FRAME_TCK = 16 * (DBIT + 2) + SB_TICK;

    logic clk;
    logic reset_n;

    uart_tx_parity_if if_e ();
    uart_tx_parity_if if_o ();

    uart_tx_parity #(.DBIT(DBIT), .SB_TICK(SB_TICK), .PARITY_ODD(1'b0)) dut_e (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_e)
    );

    uart_tx_parity #(.DBIT(DBIT), .SB_TICK(SB_TICK), .PARITY_ODD(1'b1)) dut_o (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Decoder / model state, index 0 = even instance, 1 = odd instance
    logic       in_frame  [2];
    int         tcnt      [2];
    int         bcyc      [2];
    int         dones     [2];
    logic [9:0] bits      [2];
    logic       stopb     [2];
    logic [7:0] exp_word  [2];
    int         frames    [2];
    logic [7:0] last_data [2];
    logic       last_par  [2];
    int         last_bcyc [2];
    logic [7:0] hist [$];
    logic       obs_busy;

    typedef struct {
        logic [7:0] din;
        logic       par_even;
        logic       par_odd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", name, u, act, exp, $time);
        end
    endtask

    // Parity bit that makes total ones even (odd=0) or odd (odd=1)
    function automatic logic ref_parity(input logic [7:0] w, input bit odd);
        int ones;
        ones = 0;
        for (int i = 0; i < DBIT; i++) if (w[i]) ones++;
        return odd ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    task automatic finish_frame(input int u);
        logic [7:0] data;
        logic       par;
        data = bits[u][8:1];
        par  = bits[u][9];
        chk("start_bit", u, 32'(bits[u][0]), 32'(0));
        chk("data", u, 32'(data), 32'(exp_word[u]));
        chk("parity", u, 32'(par), 32'(ref_parity(exp_word[u], u == 1)));
        chk("stop_bit", u, 32'(stopb[u]), 32'(1));
        chk("frame_ticks", u, 32'(tcnt[u]), 32'(FRAME_TCK));
        last_data[u] = data;
        last_par[u]  = par;
        last_bcyc[u] = bcyc[u];
        frames[u]++;
        if (u == 0) hist.push_back(data);
    endtask

    task automatic observe(input int u, input logic st, input logic tk, input logic [7:0] d);
        logic b_v, t_v, dn_v;
        b_v  = (u == 0) ? if_e.busy         : if_o.busy;
        t_v  = (u == 0) ? if_e.tx           : if_o.tx;
        dn_v = (u == 0) ? if_e.tx_done_tick : if_o.tx_done_tick;
        if (b_v) begin
            if (!in_frame[u]) begin
                in_frame[u] = 1'b1;
                tcnt[u]     = 0;
                bcyc[u]     = 0;
                dones[u]    = 0;
                bits[u]     = '1;
                stopb[u]    = 1'b0;
            end
            bcyc[u]++;
            if (bcyc[u] == 1) chk("tx_high_on_accept", u, 32'(t_v), 32'(1));
            if (bcyc[u] == 2) chk("tx_fall_next_edge", u, 32'(t_v), 32'(0));
            if (tk) begin
                tcnt[u]++;
                if (tcnt[u] <= 160 && (tcnt[u] % 16) == 8) bits[u][tcnt[u] / 16] = t_v;
                if (tcnt[u] == 168) stopb[u] = t_v;
            end
            if (dn_v) begin
                dones[u]++;
                finish_frame(u);
            end
        end else begin
            if (in_frame[u]) begin
                in_frame[u] = 1'b0;
                chk("done_pulses", u, 32'(dones[u]), 32'(1));
            end
            chk("idle_line", u, 32'({dn_v, t_v}), 32'(2'b01));
            if (st) exp_word[u] = d;
        end
    endtask

    // One clock: drive at falling edge, observe 1ns later
    task automatic cycle(input logic st, input logic tk, input logic [7:0] d);
        @(negedge clk);
        if_e.tx_start = st; if_e.s_tick = tk; if_e.din = d;
        if_o.tx_start = st; if_o.s_tick = tk; if_o.din = d;
        #1;
        obs_busy = if_e.busy;
        observe(0, st, tk, d);
        observe(1, st, tk, d);
    endtask

    function automatic logic tick_gen(input int dens);
        return (dens == 0) ? 1'b1 : 1'($urandom_range(0, dens) == 0);
    endfunction

    // Request w, then run until the frame completes; junk=1 toggles
    // tx_start and din randomly while the frame is in flight.
    task automatic send(input logic [7:0] w, input int dens, input bit junk);
        int  f0;
        bit  acc;
        bit  fin;
        f0  = frames[0];
        acc = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) begin
            cycle(1'b1, tick_gen(dens), w);
            if (!obs_busy) acc = 1'b1;
        end
        chk("accept_seen", 0, 32'(acc), 32'(1));
        for (int i = 0; i < 4000 && !fin; i++) begin
            cycle(junk ? 1'($urandom_range(0, 7) == 0) : 1'b0, tick_gen(dens),
                  junk ? 8'($urandom) : w);
            if (frames[0] != f0) fin = 1'b1;
        end
        chk("frame_completed", 0, 32'(fin), 32'(1));
    endtask

    initial begin
        int f0;
        bit fin;
        vectors     = 0;
        miscompares = 0;
        for (int u = 0; u < 2; u++) begin
            in_frame[u] = 1'b0; tcnt[u] = 0; bcyc[u] = 0; dones[u] = 0;
            bits[u] = '0; stopb[u] = 1'b0; exp_word[u] = '0; frames[u] = 0;
            last_data[u] = '0; last_par[u] = 1'b0; last_bcyc[u] = 0;
        end
        obs_busy = 1'b0;

        tbl[0] = '{8'h55, 1'b0, 1'b1};
        tbl[1] = '{8'h07, 1'b1, 1'b0};
        tbl[2] = '{8'hA3, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b0, 1'b1};
        tbl[4] = '{8'h12, 1'b0, 1'b1};
        tbl[5] = '{8'hFF, 1'b0, 1'b1};
        tbl[6] = '{8'h00, 1'b0, 1'b1};
        tbl[7] = '{8'h80, 1'b1, 1'b0};
        tbl[8] = '{8'hFE, 1'b1, 1'b0};
        tbl[9] = '{8'h01, 1'b1, 1'b0};

        reset_n = 1'b0;
        if_e.tx_start = 1'b0; if_e.s_tick = 1'b0; if_e.din = '0;
        if_o.tx_start = 1'b0; if_o.s_tick = 1'b0; if_o.din = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_tx", 0, 32'(if_e.tx), 32'(1));
        chk("reset_busy", 0, 32'(if_e.busy), 32'(0));
        chk("reset_done", 0, 32'(if_e.tx_done_tick), 32'(0));
        chk("reset_tx", 1, 32'(if_o.tx), 32'(1));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cycle(1'b0, 1'b1, 8'h00);

        // Table: dense ticks, fixed words with hand-computed parity
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].din, 0, 1'b0);
            chk("tbl_data", 0, 32'(last_data[0]), 32'(tbl[i].din));
            chk("tbl_par_even", 0, 32'(last_par[0]), 32'(tbl[i].par_even));
            chk("tbl_data", 1, 32'(last_data[1]), 32'(tbl[i].din));
            chk("tbl_par_odd", 1, 32'(last_par[1]), 32'(tbl[i].par_odd));
            if (i == 0) chk("busy_cycles_0x55", 0, 32'(last_bcyc[0]), 32'(FRAME_TCK));
            repeat (2) cycle(1'b0, 1'b1, 8'h00);
        end

        // Back-to-back: tx_start held high, din swapped during frame 1
        f0  = frames[0];
        fin = 1'b0;
        begin
            bit swapped;
            swapped = 1'b0;
            for (int i = 0; i < 1000 && !fin; i++) begin
                cycle(1'b1, 1'b1, swapped ? 8'h3C : 8'hA3);
                if (obs_busy) swapped = 1'b1;
                if (frames[0] == f0 + 2) fin = 1'b1;
            end
        end
        chk("b2b_two_frames", 0, 32'(fin), 32'(1));
        if (fin) begin
            chk("b2b_frame1", 0, 32'(hist[hist.size() - 2]), 32'(8'hA3));
            chk("b2b_frame2", 0, 32'(hist[hist.size() - 1]), 32'(8'h3C));
        end
        repeat (3) cycle(1'b0, 1'b1, 8'h00);

        // tx_start pulsed during DATA of a 0x12 frame
        f0  = frames[0];
        fin = 1'b0;
        cycle(1'b1, 1'b1, 8'h12);
        chk("pulse_accept_idle", 0, 32'(obs_busy), 32'(0));
        repeat (40) cycle(1'b0, 1'b1, 8'h12);
        repeat (3) cycle(1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < 400 && !fin; i++) begin
            cycle(1'b0, 1'b1, 8'hEE);
            if (frames[0] != f0) fin = 1'b1;
        end
        repeat (200) cycle(1'b0, 1'b1, 8'h00);
        chk("pulse_one_frame", 0, 32'(frames[0] - f0), 32'(1));
        chk("pulse_data", 0, 32'(last_data[0]), 32'(8'h12));

        // Reset asserted mid-DATA, then a clean 0xFF frame
        f0 = frames[0];
        cycle(1'b1, 1'b1, 8'hFF);
        repeat (50) cycle(1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_tx", 0, 32'(if_e.tx), 32'(1));
        chk("midreset_busy", 0, 32'(if_e.busy), 32'(0));
        chk("midreset_done", 0, 32'(if_e.tx_done_tick), 32'(0));
        chk("midreset_tx", 1, 32'(if_o.tx), 32'(1));
        chk("midreset_busy", 1, 32'(if_o.busy), 32'(0));
        in_frame[0] = 1'b0;
        in_frame[1] = 1'b0;
        repeat (3) cycle(1'b0, 1'b1, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) cycle(1'b0, 1'b1, 8'h00);
        chk("midreset_no_frame", 0, 32'(frames[0] - f0), 32'(0));
        send(8'hFF, 0, 1'b0);
        chk("post_reset_data", 0, 32'(last_data[0]), 32'(8'hFF));
        chk("post_reset_par", 0, 32'(last_par[0]), 32'(0));
        chk("post_reset_par", 1, 32'(last_par[1]), 32'(1));

        // Random loopback: 256 random bytes, sparse ticks on every 4th
        f0 = frames[0];
        for (int i = 0; i < 256; i++) begin
            send(8'($urandom), ((i % 4) == 0) ? 1 : 0, 1'b1);
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        repeat (3) cycle(1'b0, 1'b1, 8'h00);
        chk("random_frames", 0, 32'(frames[0] - f0), 32'(256));
        chk("random_frames", 1, 32'(frames[1] - f0), 32'(256));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
